packet_ctrl: RTL and testbench

Packet controller placed directly after the 8-byte word assembler on the UART receive path. It interprets each completed 64-bit word as either a packet header or a payload word and routes payload words to one of several destination blocks (weight/input/config buffers) through a valid/ready interface. A small FIFO absorbs destination backpressure, since the assembler cannot be stalled. Malformed headers, overflow and inter-word timeouts are flagged and aborted deterministically.

---
 rtl/pkt_pkg.sv | 26 ++
 rtl/pkt_fifo.sv | 64 ++++++
 rtl/packet_ctrl.sv | 158 +++++++++++++++
 tb/tb_packet_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared types and header field layout for the packet controller
package pkt_pkg;

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_SYNC    = 3'd1,
    ERR_HDR     = 3'd2,
    ERR_OVF     = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int SYNC_HI = 63;
  localparam int SYNC_LO = 56;
  localparam int ID_HI   = 55;
  localparam int ID_LO   = 52;
  localparam int CNT_HI  = 47;
  localparam int CNT_LO  = 40;

endpackage

// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - first-word fall-through FIFO with push, pop and flush
module pkt_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Stale storage is masked so the head reads as zero whenever nothing is queued.
  assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/packet_ctrl.sv
// rtl/packet_ctrl.sv - header parser and payload router with error and timeout handling
module packet_ctrl
  import pkt_pkg::*;
#(
  parameter int                 NUM_DST     = 4,
  parameter int                 DST_BITS    = 4,
  parameter int                 FIFO_DEPTH  = 4,
  parameter int                 TO_BITS     = 20,
  parameter logic [TO_BITS-1:0] TIMEOUT_CYC = 20'd1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         word_in,
  input  logic                word_valid,
  output logic [63:0]         dst_data,
  output logic [DST_BITS-1:0] dst_id,
  output logic                dst_valid,
  input  logic                dst_ready,
  output logic                busy,
  output logic                done,
  output logic                err_pulse,
  output logic [2:0]          err_code
);

  localparam logic [TO_BITS-1:0] TO_LAST = TIMEOUT_CYC - 1'b1;

  state_e              state_q, state_d;
  logic [DST_BITS-1:0] id_q, id_d;
  logic [7:0]          rem_q, rem_d;
  logic [TO_BITS-1:0]  to_q, to_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_pulse_q, err_pulse_d;
  logic [2:0]          err_code_q, err_code_d;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic [DST_BITS+63:0]  fifo_head;

  logic [SYNC_HI-SYNC_LO:0] hdr_sync;
  logic [ID_HI-ID_LO:0]     hdr_id;
  logic [CNT_HI-CNT_LO:0]   hdr_cnt;

  assign hdr_sync = word_in[SYNC_HI:SYNC_LO];
  assign hdr_id   = word_in[ID_HI:ID_LO];
  assign hdr_cnt  = word_in[CNT_HI:CNT_LO];

  assign fifo_pop = !fifo_empty && dst_ready;

  // to_q counts cycles since the last strobe, so a strobe loads 1 for the cycle after it.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    rem_d       = rem_q;
    to_d        = to_q;
    done_d      = 1'b0;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    case (state_q)
      IDLE: begin
        to_d = '0;
        if (word_valid) begin
          if (hdr_sync != SYNC_BYTE) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_SYNC;
          end else if ((32'(hdr_id) >= NUM_DST) || (hdr_cnt == 8'd0)) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_HDR;
          end else begin
            id_d       = DST_BITS'(hdr_id);
            rem_d      = hdr_cnt;
            err_code_d = ERR_NONE;
            to_d       = TO_BITS'(1);
            state_d    = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (word_valid) begin
          if (fifo_full && !fifo_pop) begin
            fifo_flush  = 1'b1;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_OVF;
            to_d        = '0;
            state_d     = IDLE;
          end else begin
            fifo_push = 1'b1;
            to_d      = TO_BITS'(1);
            rem_d     = rem_q - 1'b1;
            if (rem_q == 8'd1) begin
              done_d  = 1'b1;
              to_d    = '0;
              state_d = IDLE;
            end
          end
        end else if (to_q == TO_LAST) begin
          fifo_flush  = 1'b1;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          to_d        = '0;
          state_d     = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PAYLOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      rem_q       <= '0;
      to_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      rem_q       <= rem_d;
      to_q        <= to_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  pkt_fifo #(
    .WIDTH (DST_BITS + 64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({id_q, word_in}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign dst_valid = !fifo_empty;
  assign dst_data  = fifo_head[63:0];
  assign dst_id    = fifo_head[DST_BITS+63:64];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_packet_ctrl.sv
// tb/tb_packet_ctrl.sv - scoreboard bench for packet_ctrl
module tb_packet_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic [63:0] dst_data;
  logic [3:0]  dst_id;
  logic        dst_valid;
  logic        dst_ready = 1'b0;
  logic        busy, done, err_pulse;
  logic [2:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  logic [67:0] exp_q [$];
  logic [3:0]  evt_q [$];

  localparam logic [3:0] EV_DONE = 4'h0;

  packet_ctrl #(
    .NUM_DST     (4),
    .DST_BITS    (4),
    .FIFO_DEPTH  (4),
    .TO_BITS     (20),
    .TIMEOUT_CYC (20'd16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .dst_data   (dst_data),
    .dst_id     (dst_id),
    .dst_valid  (dst_valid),
    .dst_ready  (dst_ready),
    .busy       (busy),
    .done       (done),
    .err_pulse  (err_pulse),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] sync, input logic [3:0] id,
                                      input logic [7:0] n);
    return {sync, id, 4'h0, n, 40'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [63:0] w);
    word_in    = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    word_in    = '0;
  endtask

  task automatic pay(input logic [3:0] id, input logic [63:0] w, input bit deliver);
    if (deliver) exp_q.push_back({id, w});
    strobe(w);
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, dst_valid, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_errp"}, err_pulse, 0);
    check({name, "_code"}, err_code, 0);
    check({name, "_data"}, dst_data, 0);
    check({name, "_id"}, dst_id, 0);
  endtask

  // Monitor: every transfer and every done/error pulse is matched against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (dst_valid && dst_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL xfer_unexpected: got id=%0d data=%h expected none", dst_id, dst_data);
        end else begin
          check("xfer", {dst_id, dst_data}, exp_q.pop_front());
        end
      end
      if (done) begin
        if (evt_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_unexpected: got done expected no event");
        end else begin
          check("evt_done", EV_DONE, evt_q.pop_front());
        end
      end
      if (err_pulse) begin
        if (evt_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL err_unexpected: got code %0d expected no event", err_code);
        end else begin
          check("evt_err", {1'b1, err_code}, evt_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    tick();

    // Reset in the middle of a packet
    strobe(hdr(8'hA5, 4'd1, 8'd2));
    check("mid_busy", busy, 1);
    pay(4'd1, 64'hDEAD_0000_0000_0001, 1'b0);
    check("mid_valid", dst_valid, 1);
    rst = 1'b0;
    tick();
    check_zero("midrst");
    rst = 1'b1;
    tick();

    // Normal packet
    dst_ready = 1'b1;
    strobe(hdr(8'hA5, 4'd2, 8'd3));
    check("norm_busy", busy, 1);
    check("norm_code", err_code, 0);
    pay(4'd2, 64'h1111_1111_1111_1111, 1'b1);
    check("norm_head", {dst_valid, dst_id, dst_data}, {1'b1, 4'd2, 64'h1111_1111_1111_1111});
    pay(4'd2, 64'h2222_2222_2222_2222, 1'b1);
    evt_q.push_back(EV_DONE);
    pay(4'd2, 64'h3333_3333_3333_3333, 1'b1);
    check("norm_done", {done, busy}, 2'b10);
    check("norm_code2", err_code, 0);
    tick();
    check("norm_done_pulse", done, 0);

    // Bad headers
    evt_q.push_back({1'b1, 3'd1});
    strobe(hdr(8'h5A, 4'd1, 8'd1));
    check("sync_err", {err_pulse, err_code, busy}, {1'b1, 3'd1, 1'b0});
    evt_q.push_back({1'b1, 3'd2});
    strobe(hdr(8'hA5, 4'd7, 8'd1));
    check("id_err", {err_pulse, err_code, busy}, {1'b1, 3'd2, 1'b0});
    evt_q.push_back({1'b1, 3'd2});
    strobe(hdr(8'hA5, 4'd1, 8'd0));
    check("cnt_err", {err_pulse, err_code, busy}, {1'b1, 3'd2, 1'b0});
    tick();
    check("err_sticky", {err_pulse, err_code}, {1'b0, 3'd2});

    // Overflow: fifth word into a full FIFO with no pop
    dst_ready = 1'b0;
    strobe(hdr(8'hA5, 4'd0, 8'd6));
    check("ovf_clr", {busy, err_code}, {1'b1, 3'd0});
    for (int i = 0; i < 4; i++) pay(4'd0, 64'hA000 + 64'(i), 1'b0);
    check("ovf_full_valid", dst_valid, 1);
    evt_q.push_back({1'b1, 3'd3});
    pay(4'd0, 64'hA004, 1'b0);
    check("ovf_err", {err_pulse, err_code, dst_valid, busy}, {1'b1, 3'd3, 1'b0, 1'b0});

    // Full with a simultaneous pop is not an overflow
    strobe(hdr(8'hA5, 4'd1, 8'd5));
    for (int i = 0; i < 4; i++) pay(4'd1, 64'hB000 + 64'(i), 1'b1);
    dst_ready = 1'b1;
    evt_q.push_back(EV_DONE);
    pay(4'd1, 64'hB004, 1'b1);
    check("nofovf", {err_pulse, done, err_code}, {1'b0, 1'b1, 3'd0});
    repeat (6) tick();
    check("nofovf_drain", dst_valid, 0);

    // Timeout after silence
    strobe(hdr(8'hA5, 4'd3, 8'd2));
    pay(4'd3, 64'hC000, 1'b1);
    repeat (14) tick();
    check("to_early", {err_pulse, busy}, 2'b01);
    evt_q.push_back({1'b1, 3'd4});
    tick();
    check("to_err", {err_pulse, err_code, busy}, {1'b1, 3'd4, 1'b0});

    // Word arriving on the last allowed cycle wins over the timeout
    strobe(hdr(8'hA5, 4'd3, 8'd2));
    pay(4'd3, 64'hC101, 1'b1);
    repeat (14) tick();
    evt_q.push_back(EV_DONE);
    pay(4'd3, 64'hC102, 1'b1);
    check("to_win", {err_pulse, done, busy, err_code}, {1'b0, 1'b1, 1'b0, 3'd0});
    repeat (2) tick();

    // Overlapping packets share the FIFO with per-entry ids
    dst_ready = 1'b0;
    strobe(hdr(8'hA5, 4'd1, 8'd1));
    evt_q.push_back(EV_DONE);
    pay(4'd1, 64'hD001, 1'b1);
    check("ovl_done1", done, 1);
    strobe(hdr(8'hA5, 4'd3, 8'd1));
    check("ovl_busy", busy, 1);
    evt_q.push_back(EV_DONE);
    pay(4'd3, 64'hD003, 1'b1);
    check("ovl_head", {done, dst_valid, dst_id, dst_data}, {1'b1, 1'b1, 4'd1, 64'hD001});
    dst_ready = 1'b1;
    repeat (3) tick();
    check("ovl_drain", dst_valid, 0);

    repeat (4) tick();
    check("exp_left", exp_q.size(), 0);
    check("evt_left", evt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
